// File: rtl/ifetch32.sv
// ifetch32 - instruction fetch stage feeding the decoder.
// Owns the fetch PC, drives a synchronous-read instruction memory and
// redirects on decoder branches with a single squashed bubble (ARM PC+8).
// Optional branch-with-link strobe is built when IFETCH_LINK_EN is defined.

`ifndef FULLW
`define FULLW 32
`endif

module ifetch32 #(
  parameter logic [`FULLW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ib,
  input  logic              bl,
  input  logic [`FULLW-1:0] bv,
  output logic [`FULLW-1:0] imem_addr,
  output logic              imem_en,
  input  logic [`FULLW-1:0] imem_rdata,
  output logic [`FULLW-1:0] iout,
  output logic [`FULLW-1:0] ipc,
  output logic              ispb,
  output logic              link_we,
  output logic [`FULLW-1:0] link_val
);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [`FULLW-1:0] fpc_q, fpc_d;
  logic [`FULLW-1:0] ipc_q, ipc_d;
  logic              ispb_q, ispb_d;
  logic [`FULLW-1:0] br_target;

  // Branch target relative to the branch's own address plus 8; low bits forced to 0.
  assign br_target = (ipc_q + 32'd8 + bv) & 32'hFFFF_FFFC;

  // Next-state for the FSM and fetch registers; a stall holds everything.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    ipc_d   = ipc_q;
    ispb_d  = ispb_q;
    if (!stall) begin
      unique case (state_q)
        S_FILL: begin
          ipc_d   = fpc_q;
          fpc_d   = fpc_q + 32'd4;
          state_d = S_RUN;
        end
        S_RUN: begin
          ipc_d  = fpc_q;
          ispb_d = ib;
          fpc_d  = ib ? br_target : (fpc_q + 32'd4);
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // Fetch state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      fpc_q   <= RESET_PC;
      ipc_q   <= RESET_PC;
      ispb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      ipc_q   <= ipc_d;
      ispb_q  <= ispb_d;
    end
  end

  assign imem_addr = fpc_q;
  assign imem_en   = !stall;
  assign ipc       = ipc_q;
  assign ispb      = ispb_q;
  // The memory output is stale during FILL; an all-zero word is a decoder no-op.
  assign iout      = (state_q == S_FILL) ? '0 : imem_rdata;

`ifdef IFETCH_LINK_EN
  logic              link_we_q, link_we_d;
  logic [`FULLW-1:0] link_val_q, link_val_d;

  // One-cycle link strobe for a taken BL; held across stalls.
  always_comb begin
    link_we_d  = link_we_q;
    link_val_d = link_val_q;
    if (!stall) begin
      if (state_q == S_RUN && ib && bl) begin
        link_we_d  = 1'b1;
        link_val_d = ipc_q + 32'd4;
      end else begin
        link_we_d  = 1'b0;
        link_val_d = '0;
      end
    end
  end

  // Link strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_we_q  <= 1'b0;
      link_val_q <= '0;
    end else begin
      link_we_q  <= link_we_d;
      link_val_q <= link_val_d;
    end
  end

  assign link_we  = link_we_q;
  assign link_val = link_val_q;
`else
  logic unused_bl;
  assign unused_bl = bl;
  assign link_we   = 1'b0;
  assign link_val  = '0;
`endif

endmodule

// File: tb/tb_ifetch32.sv
// Self-checking bench for ifetch32: directed vector table, hand-written
// stall / async-reset / wrap sequences, then randomized traffic against a
// fetch-stream reference model.

module tb_ifetch32;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFETCH_LINK_EN
  localparam bit LINK_ON = 1'b1;
`else
  localparam bit LINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ib = 1'b0;
  logic        bl = 1'b0;
  logic [31:0] bv = '0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] iout;
  logic [31:0] ipc;
  logic        ispb;
  logic        link_we;
  logic [31:0] link_val;

  int n_cmp = 0;
  int n_bad = 0;

  ifetch32 #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .ib        (ib),
    .bl        (bl),
    .bv        (bv),
    .imem_addr (imem_addr),
    .imem_en   (imem_en),
    .imem_rdata(imem_rdata),
    .iout      (iout),
    .ipc       (ipc),
    .ispb      (ispb),
    .link_we   (link_we),
    .link_val  (link_val)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address (never zero).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h1234_5678) | 32'h1;
  endfunction

  // Synchronous-read memory that holds its output when disabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  // Reference model: the address currently presented, the next address to
  // be fetched, whether the pipe is still filling, and the link pulse.
  bit          m_fill;
  logic [31:0] m_ipc, m_next;
  bit          m_ispb, m_lwe;
  logic [31:0] m_lval;

  task automatic model_reset();
    m_fill = 1'b1; m_ipc = RST_PC; m_next = RST_PC;
    m_ispb = 1'b0; m_lwe = 1'b0; m_lval = '0;
  endtask

  task automatic model_advance(input bit i, input bit l, input logic [31:0] v);
    logic [31:0] here;
    if (m_fill) begin
      m_ipc  = m_next;
      m_next = m_next + 32'd4;
      m_fill = 1'b0;
      m_ispb = 1'b0;
      m_lwe  = 1'b0;
      m_lval = '0;
    end else begin
      here   = m_ipc;
      m_ipc  = m_next;
      m_next = i ? ((here + 32'd8 + v) & ~32'd3) : (m_next + 32'd4);
      m_ispb = i;
      m_lwe  = i && l;
      m_lval = (i && l) ? here + 32'd4 : 32'd0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ipc"},      ipc, m_ipc);
    chk({tag, ".addr"},     imem_addr, m_next);
    chk({tag, ".ispb"},     32'(ispb), 32'(m_ispb));
    chk({tag, ".iout"},     iout, m_fill ? 32'd0 : mem_word(m_ipc));
    chk({tag, ".en"},       32'(imem_en), 32'(!stall));
    chk({tag, ".link_we"},  32'(link_we), LINK_ON ? 32'(m_lwe) : 32'd0);
    chk({tag, ".link_val"}, link_val, LINK_ON ? m_lval : 32'd0);
  endtask

  // Drive inputs, take one clock edge, update the model, compare.
  task automatic step(input string tag, input bit s, input bit i, input bit l, input logic [31:0] v);
    stall = s; ib = i; bl = l; bv = v;
    @(posedge clk);
    if (!s) model_advance(i, l, v);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; ib = 1'b0; bl = 1'b0; bv = '0;
    #1;
    model_reset();
    check_model("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_model("fill");
  endtask

  typedef struct {
    bit          st;
    bit          br;
    bit          lk;
    logic [31:0] off;
    logic [31:0] e_ipc;
    logic [31:0] e_addr;
    bit          e_ispb;
    bit          e_lwe;
    logic [31:0] e_lval;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit st, bit br, bit lk, logic [31:0] off, logic [31:0] e_ipc,
                              logic [31:0] e_addr, bit e_ispb, bit e_lwe, logic [31:0] e_lval);
    vec_t r;
    r.st = st; r.br = br; r.lk = lk; r.off = off; r.e_ipc = e_ipc; r.e_addr = e_addr;
    r.e_ispb = e_ispb; r.e_lwe = e_lwe; r.e_lval = e_lval;
    return r;
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 0, 32'h0,         32'h00, 32'h04, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,         32'h04, 32'h08, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,         32'h08, 32'h0C, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h10,        32'h0C, 32'h20, 1, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,         32'h20, 32'h24, 0, 0, 32'h0);
    tbl[5]  = mk(0, 1, 0, 32'hFFFF_FFE8, 32'h24, 32'h10, 1, 0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h0,         32'h10, 32'h14, 0, 0, 32'h0);
    tbl[7]  = mk(0, 1, 0, 32'h28,        32'h14, 32'h40, 1, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,         32'h40, 32'h44, 0, 0, 32'h0);
    tbl[9]  = mk(0, 1, 1, 32'h8,         32'h44, 32'h50, 1, 1, 32'h44);
    tbl[10] = mk(0, 0, 0, 32'h0,         32'h50, 32'h54, 0, 0, 32'h0);
    tbl[11] = mk(0, 0, 0, 32'h0,         32'h54, 32'h58, 0, 0, 32'h0);
    tbl[12] = mk(1, 0, 0, 32'h0,         32'h54, 32'h58, 0, 0, 32'h0);
    tbl[13] = mk(0, 1, 0, 32'h13,        32'h58, 32'h6C, 1, 0, 32'h0);
    tbl[14] = mk(0, 0, 0, 32'h0,         32'h6C, 32'h70, 0, 0, 32'h0);

    // Directed vector table from reset.
    do_reset();
    foreach (tbl[k]) begin
      stall = tbl[k].st; ib = tbl[k].br; bl = tbl[k].lk; bv = tbl[k].off;
      @(posedge clk);
      if (!tbl[k].st) model_advance(tbl[k].br, tbl[k].lk, tbl[k].off);
      #1;
      chk($sformatf("vec%0d.ipc", k),  ipc, tbl[k].e_ipc);
      chk($sformatf("vec%0d.addr", k), imem_addr, tbl[k].e_addr);
      chk($sformatf("vec%0d.ispb", k), 32'(ispb), 32'(tbl[k].e_ispb));
      chk($sformatf("vec%0d.iout", k), iout, mem_word(tbl[k].e_ipc));
      chk($sformatf("vec%0d.en", k),   32'(imem_en), 32'(!tbl[k].st));
      chk($sformatf("vec%0d.lwe", k),  32'(link_we), LINK_ON ? 32'(tbl[k].e_lwe) : 32'd0);
      chk($sformatf("vec%0d.lval", k), link_val, LINK_ON ? tbl[k].e_lval : 32'd0);
    end

    // Address wrap: branch to FFFF_FFF8 and run across zero.
    step("wrap0", 0, 1, 0, 32'hFFFF_FF84);
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFF8);
    step("wrap1", 0, 0, 0, 32'h0);
    step("wrap2", 0, 0, 0, 32'h0);
    chk("wrap_addr0", imem_addr, 32'h0);
    step("wrap3", 0, 0, 0, 32'h0);
    chk("wrap_ipc0", ipc, 32'h0);

    // Stall held three cycles at ipc=4 with a BL pending.
    do_reset();
    step("s_a", 0, 0, 0, 32'h0);
    step("s_b", 0, 0, 0, 32'h0);
    for (int n = 0; n < 3; n++) step("s_hold", 1, 1, 1, 32'h10);
    chk("stall_ipc", ipc, 32'h4);
    chk("stall_iout", iout, mem_word(32'h4));
    step("s_rel", 0, 1, 1, 32'h10);
    chk("stall_rel_ipc", ipc, 32'h8);
    chk("stall_rel_tgt", imem_addr, 32'h1C);
    chk("stall_rel_ispb", 32'(ispb), 32'd1);
    step("s_lk1", 1, 0, 0, 32'h0);
    step("s_lk2", 1, 0, 0, 32'h0);
    step("s_go", 0, 0, 0, 32'h0);
    chk("stall_tgt_ipc", ipc, 32'h1C);

    // Asynchronous reset while ispb=1, then a fresh fill.
    step("ar_br", 0, 1, 0, 32'h20);
    chk("ar_ispb", 32'(ispb), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_ipc", ipc, RST_PC);
    chk("ar_ispb0", 32'(ispb), 32'd0);
    chk("ar_addr", imem_addr, RST_PC);
    chk("ar_iout", iout, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_model("ar_fill");
    for (int n = 0; n < 4; n++) step("ar_run", 0, 0, 0, 32'h0);
    chk("ar_ipc_c", ipc, 32'hC);

    // Randomized traffic; ib is suppressed during ispb as the decoder would.
    for (int n = 0; n < 600; n++) begin
      bit          s, i, l;
      logic [31:0] v;
      s = ($urandom_range(0, 3) == 0);
      i = !m_ispb && ($urandom_range(0, 3) == 0);
      l = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       v = {{20{1'b0}}, 12'($urandom)} << 2;
        1:       v = 32'hFFFF_F000 | (32'($urandom_range(0, 1023)) << 2);
        default: v = $urandom;
      endcase
      step("rnd", s, i, l, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
